// File: rtl/typed_chan_timer.sv
// Purpose     : bank of NUM_CH countdown timers sharing one round-robin completion port.
// Latency     : a start accepted with count N enters WAIT N+1 edges later; done_* is
//               combinational from the registered channel states and arbiter lock.
// Backpressure: done_ready=0 locks the presented grant (channel and tag held stable).
//               A waiting channel refuses new starts until its completion is taken.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start_valid/ready        per-channel load handshake (ready only while IDLE)
//   start_count, start_tag   packed per-channel load count / tag
//   done_valid/ready         shared completion handshake
//   done_ch, done_tag        presented channel index and its captured tag
//   ch_state                 packed 3-bit state per channel (IDLE=2, RUN=3, WAIT=4)
//   busy                     any channel not IDLE
module typed_chan_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH-1:0]                       start_valid,
  output logic [NUM_CH-1:0]                       start_ready,
  input  logic [NUM_CH*CNT_W-1:0]                 start_count,
  input  logic [NUM_CH*TAG_W-1:0]                 start_tag,
  output logic                                    done_valid,
  input  logic                                    done_ready,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] done_ch,
  output logic [TAG_W-1:0]                        done_tag,
  output logic [3*NUM_CH-1:0]                     ch_state,
  output logic                                    busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Arbiter-side types live at module scope; channel types live per generate scope.
  typedef logic [CH_W-1:0]  ch_idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [NUM_CH-1:0] wait_vec;
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] hs_vec;
  tag_t              tag_arr [NUM_CH];

  logic    sel_vld;
  ch_idx_t sel_idx;
  ch_idx_t ptr_q, ptr_d;
  ch_idx_t gnt_q, gnt_d;
  logic    lock_q, lock_d;

  // ------------------------------------------------------------------
  // Per-channel countdown FSMs
  // ------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    typedef enum logic [2:0] {
      IDLE = 3'd2,
      RUN  = 3'd3,
      WAIT = 3'd4
    } state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    tag_t   tag_q, tag_d;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tag_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tag_q   <= tag_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      case (state_q)
        IDLE: begin
          if (start_valid[i]) begin
            cnt_d   = cnt_t'(start_count[i*CNT_W +: CNT_W]);
            tag_d   = tag_t'(start_tag[i*TAG_W +: TAG_W]);
            state_d = RUN;
          end
        end
        RUN: begin
          // Zero is checked before decrementing, so count N spends N+1 edges in RUN.
          if (cnt_q == '0) state_d = WAIT;
          else             cnt_d   = cnt_q - cnt_t'(1);
        end
        WAIT: begin
          if (hs_vec[i]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign start_ready[i]        = (state_q == IDLE);
    assign wait_vec[i]           = (state_q == WAIT);
    assign busy_vec[i]           = (state_q != IDLE);
    assign ch_state[3*i +: 3]    = state_q;
    assign tag_arr[i]            = tag_q;
    assign hs_vec[i]             = sel_vld && done_ready && (sel_idx == ch_idx_t'(i));
  end

  // ------------------------------------------------------------------
  // Round-robin completion arbiter
  // ------------------------------------------------------------------
  // Scan downward in distance from ptr so the last hit is the nearest WAIT
  // channel at or after ptr. A locked grant always points at a WAIT channel,
  // since only its own handshake (which also clears the lock) leaves WAIT.
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    if (lock_q) begin
      sel_vld = 1'b1;
      sel_idx = gnt_q;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (wait_vec[idx[CH_W-1:0]]) begin
          sel_vld = 1'b1;
          sel_idx = idx[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    if (sel_vld && done_ready) begin
      lock_d = 1'b0;
      ptr_d  = (sel_idx == ch_idx_t'(NUM_CH - 1)) ? '0 : sel_idx + ch_idx_t'(1);
    end else if (sel_vld) begin
      lock_d = 1'b1;
      gnt_d  = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

  assign done_valid = sel_vld;
  assign done_ch    = sel_idx;
  assign done_tag   = tag_arr[sel_idx];
  assign busy       = |busy_vec;

endmodule

// File: tb/tb_typed_chan_timer.sv
// Directed bench for typed_chan_timer (NUM_CH=4, CNT_W=8, TAG_W=4).
// A table of per-edge vectors covers contention and a single-channel run;
// hand sequences cover zero/max counts, lock under backpressure and mid-run reset.
module tb_typed_chan_timer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_valid;
  logic [3:0]  start_ready;
  logic [31:0] start_count;
  logic [15:0] start_tag;
  logic        done_valid;
  logic        done_ready;
  logic [1:0]  done_ch;
  logic [3:0]  done_tag;
  logic [11:0] ch_state;
  logic        busy;

  int n_chk;
  int n_err;

  typedef struct {
    logic [3:0]  sv;
    logic [31:0] cnt;
    logic [15:0] tag;
    logic        dr;
    logic [11:0] e_state;
    logic        e_dv;
    logic [1:0]  e_ch;
    logic [3:0]  e_tag;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  typed_chan_timer #(.NUM_CH(4), .CNT_W(8), .TAG_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_count (start_count),
    .start_tag   (start_tag),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_ch     (done_ch),
    .done_tag    (done_tag),
    .ch_state    (ch_state),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] sv, input logic [31:0] cnt, input logic [15:0] tag,
                     input logic dr, input logic [11:0] est, input logic edv,
                     input logic [1:0] ech, input logic [3:0] etag, input logic ebusy);
    vec_t v;
    v.sv = sv; v.cnt = cnt; v.tag = tag; v.dr = dr;
    v.e_state = est; v.e_dv = edv; v.e_ch = ech; v.e_tag = etag; v.e_busy = ebusy;
    tbl.push_back(v);
  endtask

  function automatic logic [3:0] rdy_of(input logic [11:0] st);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (st[3*c +: 3] == 3'd2);
    return r;
  endfunction

  initial begin
    int run_cnt;
    n_chk = 0;
    n_err = 0;

    // Contention: all four channels, count 3, tags 1..4, consumer always ready.
    add(4'hF, 32'h03030303, 16'h4321, 1'b1, 12'h6DB, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h6DB, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h6DB, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h6DB, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h924, 1'b1, 2'd0, 4'h1, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h922, 1'b1, 2'd1, 4'h2, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h912, 1'b1, 2'd2, 4'h3, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h892, 1'b1, 2'd3, 4'h4, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h492, 1'b0, 2'd0, 4'h0, 1'b0);
    // Single channel: ch2 count 5 tag A (ptr is 0 after the contention round).
    add(4'h4, 32'h00050000, 16'h0A00, 1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h4D2, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h512, 1'b1, 2'd2, 4'hA, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h492, 1'b0, 2'd0, 4'h0, 1'b0);
    // ptr is now 3: ch1 and ch3 finish together, ch3 must be presented first.
    add(4'hA, 32'h00000000, 16'h6050, 1'b0, 12'h69A, 1'b0, 2'd0, 4'h0, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b0, 12'h8A2, 1'b1, 2'd3, 4'h6, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h4A2, 1'b1, 2'd1, 4'h5, 1'b1);
    add(4'h0, 32'h0,        16'h0,    1'b1, 12'h492, 1'b0, 2'd0, 4'h0, 1'b0);

    // Reset for two edges.
    rst_n = 1'b0; start_valid = '0; start_count = '0; start_tag = '0; done_ready = 1'b0;
    step();
    step();
    chk("rst_state", ch_state, 12'h492);
    chk("rst_ready", start_ready, 4'hF);
    chk("rst_dv", done_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ch", done_ch, 2'd0);
    chk("rst_tag", done_tag, 4'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      start_valid = tbl[i].sv;
      start_count = tbl[i].cnt;
      start_tag   = tbl[i].tag;
      done_ready  = tbl[i].dr;
      step();
      chk($sformatf("v%0d_state", i), ch_state, tbl[i].e_state);
      chk($sformatf("v%0d_ready", i), start_ready, rdy_of(tbl[i].e_state));
      chk($sformatf("v%0d_dv", i), done_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_dv) begin
        chk($sformatf("v%0d_ch", i), done_ch, tbl[i].e_ch);
        chk($sformatf("v%0d_tag", i), done_tag, tbl[i].e_tag);
      end
    end
    start_valid = '0; done_ready = 1'b0;

    // Zero count on ch0: WAIT one edge after acceptance.
    start_valid = 4'h1; start_count = 32'h0; start_tag = 16'h0007;
    step();
    chk("z_run", ch_state[2:0], 3'd3);
    start_valid = '0;
    step();
    chk("z_wait", ch_state[2:0], 3'd4);
    chk("z_dv", done_valid, 1'b1);
    chk("z_ch", done_ch, 2'd0);
    chk("z_tag", done_tag, 4'h7);
    done_ready = 1'b1;
    step();
    chk("z_idle", ch_state[2:0], 3'd2);
    done_ready = 1'b0;

    // Max count on ch0: 255 edges still in RUN, WAIT on edge 256.
    start_valid = 4'h1; start_count = 32'h000000FF; start_tag = 16'h0009;
    step();
    start_valid = '0;
    run_cnt = 0;
    for (int k = 1; k < 256; k++) begin
      step();
      if (ch_state[2:0] == 3'd3) run_cnt++;
    end
    chk("max_run_edges", run_cnt, 255);
    step();
    chk("max_wait", ch_state[2:0], 3'd4);
    chk("max_tag", done_tag, 4'h9);

    // A start offered during WAIT is refused, including on the handshake edge.
    start_valid = 4'h1; start_count = 32'h0; start_tag = 16'h000E;
    step();
    chk("w_hold", ch_state[2:0], 3'd4);
    chk("w_rdy", start_ready[0], 1'b0);
    done_ready = 1'b1;
    step();
    chk("w_idle", ch_state[2:0], 3'd2);
    done_ready = 1'b0;
    step();
    chk("w_restart", ch_state[2:0], 3'd3);
    start_valid = '0;
    step();
    done_ready = 1'b1;
    step();
    chk("w_done", ch_state, 12'h492);
    done_ready = 1'b0;

    // Lock: after reset ptr=0; ch1 waits first, ch0 arrives while stalled.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start_valid = 4'h3; start_count = 32'h00000002; start_tag = 16'h00BC;
    step();
    start_valid = '0;
    step();
    chk("l_dv", done_valid, 1'b1);
    chk("l_ch_a", done_ch, 2'd1);
    step();
    step();
    chk("l_ch0_wait", ch_state[2:0], 3'd4);
    chk("l_ch_b", done_ch, 2'd1);
    chk("l_tag_b", done_tag, 4'hB);
    step();
    chk("l_ch_c", done_ch, 2'd1);
    done_ready = 1'b1;
    step();
    chk("l_next_dv", done_valid, 1'b1);
    chk("l_next_ch", done_ch, 2'd0);
    chk("l_next_tag", done_tag, 4'hC);
    chk("l_ch1_idle", ch_state[5:3], 3'd2);
    step();
    chk("l_clear", ch_state, 12'h492);
    done_ready = 1'b0;

    // Mid-run reset: ptr is 1, ch3 in RUN, ch1 in WAIT presenting.
    start_valid = 4'hA; start_count = 32'h32000000; start_tag = 16'h3040;
    step();
    start_valid = '0;
    step();
    chk("r_pre_dv", done_valid, 1'b1);
    chk("r_pre_ch", done_ch, 2'd1);
    rst_n = 1'b0; done_ready = 1'b1;
    step();
    rst_n = 1'b1; done_ready = 1'b0;
    chk("r_state", ch_state, 12'h492);
    chk("r_dv", done_valid, 1'b0);
    chk("r_busy", busy, 1'b0);
    step();
    chk("r_dv_later", done_valid, 1'b0);
    // ptr must be back at 0: ch0 beats ch1 when both finish together.
    start_valid = 4'h3; start_count = 32'h0; start_tag = 16'h0021;
    step();
    start_valid = '0;
    step();
    chk("r_ptr_ch", done_ch, 2'd0);
    chk("r_ptr_tag", done_tag, 4'h1);
    done_ready = 1'b1;
    step();
    step();
    chk("r_end", ch_state, 12'h492);
    done_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/typed_chan_timer.md
Name: typed_chan_timer

Overview:
Multi-channel countdown timer bank with a round-robin completion arbiter. Each channel accepts a load count and tag through a valid/ready handshake, then counts down to zero. It then waits to report its tag on a single shared completion port. The block exercises scoped typedefs and explicitly encoded enums in a parametrised generate structure. It is a synthesis and formal target alongside the other SV-types blocks.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 8, countdown counter width in bits (2..32)
TAG_W, 4, width of the per-request tag returned on completion (1..16)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
start_valid  input  NUM_CH  per-channel load request
start_ready  output  NUM_CH  per-channel load accept (1 only in IDLE)
start_count  input  NUM_CH*CNT_W  channel i count at [i*CNT_W +: CNT_W]
start_tag  input  NUM_CH*TAG_W  channel i tag at [i*TAG_W +: TAG_W]
done_valid  output  1  a completion is presented
done_ready  input  1  consumer accepts the presented completion
done_ch  output  max(1,$clog2(NUM_CH))  index of the presented channel
done_tag  output  TAG_W  tag captured by the presented channel
ch_state  output  3*NUM_CH  channel i state encoding at [3*i +: 3]
busy  output  1  OR over channels of (state != IDLE)

Behaviour:
- Structure: one generate block per channel.
  - The state type is an enum logic [2:0] declared inside that generate scope, with IDLE=3'd2, RUN=3'd3, WAIT=3'd4.
  - The counter type is typedef logic [CNT_W-1:0], also declared in that scope.
  - The arbiter uses module-scope types only.
- Reset (rst_n=0 at an edge) sets:
  - every channel to IDLE, so ch_state is all 3'b010;
  - counters and tags to 0;
  - RR pointer to 0 and lock to 0;
  - done_valid=0, done_ch=0, done_tag=0, busy=0, start_ready all 1.
- Reset mid-operation discards all pending counts and completions. No done handshake completes on a reset edge.
- IDLE:
  - start_ready[i]=1.
  - On an edge with start_valid[i]=1, capture count and tag, then go to RUN.
- RUN:
  - If cnt==0, go to WAIT; otherwise cnt<=cnt-1.
  - A request accepted at edge t with count N enters WAIT at edge t+N+1.
  - N=0 enters WAIT at edge t+1. N=2^CNT_W-1 enters WAIT at edge t+2^CNT_W. No wrap.
- WAIT:
  - The channel is eligible for arbitration.
  - It returns to IDLE on the edge where it is granted with done_valid&&done_ready.
  - start_ready[i] is 0 in WAIT. A new start is accepted no earlier than the edge after the return to IDLE.
- Illegal state encodings (not 2/3/4) go to IDLE on the next edge.
- Arbiter selection:
  - When lock=0, select the first WAIT channel at or after ptr, scanning upward modulo NUM_CH.
  - When lock=1, hold the registered grant.
- Arbiter outputs:
  - done_valid, done_ch and done_tag are combinational from the selection.
  - done_valid=1 iff a selection exists.
- Stability: if done_valid=1 and done_ready=0 at an edge, set lock=1 and register the grant. done_ch and done_tag then stay stable until the handshake, even if higher-priority channels enter WAIT.
- Handshake edge: lock<=0 and ptr<=(granted+1) mod NUM_CH. The next selection is visible the following cycle.
- Completion rate is at most one per cycle.
- done_ready while done_valid=0 has no effect.
- busy and ch_state are combinational from the registered states.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, NUM_CH=4 -> ch_state=12'h492, start_ready=4'hF, done_valid=0, busy=0.
- Single channel: ch2 start_count=8'd5, tag=4'hA, accepted at edge t -> ch_state[8:6]=3'd3 after edges t..t+5, 3'd4 after t+6; then done_valid=1, done_ch=2, done_tag=4'hA; done_ready=1 -> ch2 IDLE and ptr=3 next cycle.
- Zero and max count: ch0 count 0 -> WAIT one edge after acceptance; ch0 count 8'hFF -> WAIT exactly 256 edges after acceptance.
- Contention: all 4 channels start count 3 on the same edge with tags 1,2,3,4 and done_ready=1 -> done_ch 0,1,2,3 with tags 1..4 on 4 consecutive cycles; busy falls after the last handshake; ptr=0.
- Lock/backpressure:
  - Stimulus: ptr=0, ch1 alone in WAIT, done_ready=0; ch0 then enters WAIT.
  - Required: done_ch stays 1 with done_tag unchanged until done_ready=1, then done_ch=0 on the next cycle.
- Reset mid-operation: rst_n=0 for one edge while ch3 is in RUN and ch1 is in WAIT with done_valid=1 -> all IDLE next cycle, done_valid=0, ptr=0, no completion reported.
